// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receive FIFO: byte head, occupancy and sticky error flags.
// Latency: pure wiring, no storage.
// Backpressure: the consumer drives i_rd when it is ready for a byte; nothing is lost until the FIFO is full.
// Ports:
//   master (the receiver) drives o_data/o_empty/o_full/o_count/o_frame_err/o_overrun.
//   slave  (the debugger) drives i_rd (pop head) and i_clr_err (clear both flags).
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic                          i_rd;
  logic                          i_clr_err;
  logic [DATA_BITS-1:0]          o_data;
  logic                          o_empty;
  logic                          o_full;
  logic [$clog2(FIFO_DEPTH):0]   o_count;
  logic                          o_frame_err;
  logic                          o_overrun;

  modport master (
    input  i_rd, i_clr_err,
    output o_data, o_empty, o_full, o_count, o_frame_err, o_overrun
  );

  modport slave (
    output i_rd, i_clr_err,
    input  o_data, o_empty, o_full, o_count, o_frame_err, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// Latency: byte visible one cycle after the mid-stop-bit sample (~9.5 bit times after the start edge).
// Backpressure: none on the line; a good byte arriving while full is dropped and flagged as overrun.
// Ports:
//   i_clk, i_rst  - system clock, synchronous active-high reset
//   i_uart_rx     - asynchronous serial input, idle high
//   bus (master)  - i_rd/i_clr_err in; o_data/o_empty/o_full/o_count/o_frame_err/o_overrun out
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 163,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  uart_rx_fifo_if.master        bus
);

  localparam int BW = (BAUD_DIV > 1)   ? $clog2(BAUD_DIV)   : 1;
  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int NW = (DATA_BITS > 1)  ? $clog2(DATA_BITS)  : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Line synchronizer; resets to the idle (high) level so reset never looks like a start bit.
  logic rx_meta, rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample tick; start detection is not phase-aligned to it.
  logic [BW-1:0] baud_cnt;
  logic          tick;

  assign tick = (baud_cnt == BAUD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst)     baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + BW'(1);
  end

  // Deframing FSM.
  state_t               state, state_nxt;
  logic [SW-1:0]        s, s_nxt;
  logic [NW-1:0]        n, n_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 push_req;
  logic                 ferr_set;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    shreg_nxt = shreg;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          s_nxt     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s == S_MID) begin
            // Re-check the line mid start bit so short glitches are rejected.
            if (!rx_s) begin
              state_nxt = ST_DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            s_nxt     = '0;
            n_nxt     = n + NW'(1);
            if (n == N_LAST) state_nxt = ST_STOP;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s == S_LAST) begin
            if (rx_s) begin
              push_req  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = ST_BREAK;
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      ST_BREAK: begin
        // Hold here until the line idles so a long break yields a single error.
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW-1:0]        count;
  logic                 empty, full;
  logic                 do_pop, do_push, ovr_set;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_P);
  assign do_pop  = bus.i_rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Sticky flags; a new error in the clearing cycle takes priority.
  logic frame_err, overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)           frame_err <= 1'b1;
      else if (bus.i_clr_err) frame_err <= 1'b0;
      if (ovr_set)            overrun   <= 1'b1;
      else if (bus.i_clr_err) overrun   <= 1'b0;
    end
  end

  assign bus.o_data      = mem[rd_ptr[AW-1:0]];
  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_count     = count;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BAUD_DIV = 4;
  localparam int BIT_T    = BAUD_DIV * 16;
  localparam int DEPTH    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus();

  uart_rx_fifo #(
    .BAUD_DIV  (BAUD_DIV),
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_uart_rx(rx),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_T) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_T) @(negedge clk);
  endtask

  // Scoreboard side of a good frame: queued if there is room, otherwise an overrun.
  task automatic expect_byte(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovr = 1'b1;
  endtask

  // Called on a negedge: compare the head against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_nonempty"}, 32'(bus.o_empty), 32'd0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, 32'(bus.o_data), 32'(e));
    bus.i_rd = 1'b1;
    @(negedge clk);
    bus.i_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_rd      = 1'b0;
    bus.i_clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_empty", 32'(bus.o_empty),     32'd1);
    check("rst_full",  32'(bus.o_full),      32'd0);
    check("rst_count", 32'(bus.o_count),     32'd0);
    check("rst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("rst_ovr",   32'(bus.o_overrun),   32'd0);

    // Single byte
    send_frame(8'h55, 1'b1);
    expect_byte(8'h55);
    check("t1_empty", 32'(bus.o_empty), 32'd0);
    check("t1_count", 32'(bus.o_count), 32'(exp_q.size()));
    pop_check("t1_data");
    check("t1_empty_after", 32'(bus.o_empty),     32'd1);
    check("t1_ferr",        32'(bus.o_frame_err), 32'd0);
    check("t1_ovr",         32'(bus.o_overrun),   32'd0);
    repeat (16) @(negedge clk);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t2_empty", 32'(bus.o_empty),     32'd1);
    check("t2_ferr",  32'(bus.o_frame_err), 32'd0);
    send_frame(8'hC3, 1'b1);
    expect_byte(8'hC3);
    pop_check("t2_data");
    repeat (16) @(negedge clk);

    // Framing error followed by a long break: one error only
    send_frame(8'hA3, 1'b0);
    repeat (100) @(negedge clk);
    check("t3_ferr_set", 32'(bus.o_frame_err), 32'd1);
    check("t3_empty",    32'(bus.o_empty),     32'd1);
    pulse_clr();
    repeat (600) @(negedge clk);
    check("t3_ferr_once", 32'(bus.o_frame_err), 32'd0);
    check("t3_empty2",    32'(bus.o_empty),     32'd1);
    rx = 1'b1;
    repeat (BIT_T) @(negedge clk);
    send_frame(8'h0F, 1'b1);
    expect_byte(8'h0F);
    pop_check("t3_data");
    check("t3_ferr_clear", 32'(bus.o_frame_err), 32'd0);
    repeat (16) @(negedge clk);

    // Fill, overflow, drain
    for (int b = 0; b < 9; b++) begin
      send_frame(8'(b), 1'b1);
      expect_byte(8'(b));
      repeat (8) @(negedge clk);
      if (b == 7) begin
        check("t4_full",  32'(bus.o_full),     32'd1);
        check("t4_count", 32'(bus.o_count),    32'(exp_q.size()));
        check("t4_ovr0",  32'(bus.o_overrun),  32'd0);
      end
    end
    check("t4_ovr",   32'(bus.o_overrun), 32'(exp_ovr));
    check("t4_full2", 32'(bus.o_full),    32'd1);
    for (int k = 0; k < DEPTH; k++) pop_check("t4_data");
    check("t4_empty", 32'(bus.o_empty), 32'd1);
    pulse_clr();
    exp_ovr = 1'b0;
    check("t4_ovr_clear", 32'(bus.o_overrun), 32'(exp_ovr));

    // Full FIFO with a pop in the exact push cycle
    for (int b = 0; b < DEPTH; b++) begin
      send_frame(8'h10 + 8'(b), 1'b1);
      expect_byte(8'h10 + 8'(b));
      repeat (8) @(negedge clk);
    end
    check("t5_full", 32'(bus.o_full), 32'd1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        int k;
        for (k = 0; k < 12 * BIT_T && !dut.push_req; k++) @(negedge clk);
        check("t5_push_seen", 32'(dut.push_req), 32'd1);
        pop_check("t5_pop_at_push");
        exp_q.push_back(8'h99);
      end
    join
    repeat (8) @(negedge clk);
    check("t5_ovr",   32'(bus.o_overrun), 32'd0);
    check("t5_count", 32'(bus.o_count),   32'(exp_q.size()));
    for (int k = 0; k < DEPTH; k++) pop_check("t5_data");
    check("t5_empty", 32'(bus.o_empty), 32'd1);

    // Reset mid-frame discards the partial byte and the buffered one
    send_frame(8'hEE, 1'b1);
    repeat (8) @(negedge clk);
    check("t6_pre_empty", 32'(bus.o_empty), 32'd0);
    begin
      logic [7:0] pb;
      pb = 8'h77;
      rx = 1'b0;
      repeat (BIT_T) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rx = pb[i];
        repeat (BIT_T) @(negedge clk);
      end
      rx = pb[4];
      repeat (BIT_T / 2) @(negedge clk);
    end
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (BIT_T) @(negedge clk);
    check("t6_empty", 32'(bus.o_empty),     32'd1);
    check("t6_count", 32'(bus.o_count),     32'd0);
    check("t6_ferr",  32'(bus.o_frame_err), 32'd0);
    check("t6_ovr",   32'(bus.o_overrun),   32'd0);
    send_frame(8'h3C, 1'b1);
    expect_byte(8'h3C);
    pop_check("t6_data");
    check("t6_empty2", 32'(bus.o_empty),     32'd1);
    check("t6_ferr2",  32'(bus.o_frame_err), 32'd0);
    check("t6_ovr2",   32'(bus.o_overrun),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
